// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes, FSM encoding and divide-by-zero helper for alu_sequencer
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;
  localparam logic [7:0] DIV0_RESULT = 8'hFF;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  function automatic logic div_by_zero(input logic [3:0] op, input logic [7:0] b);
    return op == OP_DIV && b == 8'h00;
  endfunction
endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: synchronous command FIFO with full/empty flags
// Ports: clk, rst_n (async active-low), push/din write side, pop/dout read side
// (dout shows the head entry combinationally), full, empty.
module alu_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: queues ALU commands, issues them one at a time and returns tagged results
// Ports: clk, rst_n (async active-low); cmd_* valid/ready command channel (cmd_acc only
// with ALU_SEQ_ACCUM_EN); alu_a/alu_b/alu_sel registered ALU drive, alu_out/alu_carry
// ALU result; rsp_* valid/ready response channel.
// Optional feature macro: ALU_SEQ_ACCUM_EN (accumulator replaces operand A when cmd_acc=1).
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
`ifdef ALU_SEQ_ACCUM_EN
  input  logic             cmd_acc,
`endif
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag
);
`ifdef ALU_SEQ_ACCUM_EN
  localparam int EW = TAG_W + 21;
  logic [7:0] acc;
`else
  localparam int EW = TAG_W + 20;
`endif
  state_t state, next_state;
  logic [EW-1:0] din, dout;
  logic full, empty, pop;
  logic [3:0] head_op;
  logic [7:0] head_a, head_b, issue_a, res_next;
  logic [TAG_W-1:0] head_tag, tag_q;
`ifdef ALU_SEQ_ACCUM_EN
  assign din = {cmd_op, cmd_a, cmd_b, cmd_tag, cmd_acc};
  assign issue_a = dout[0] ? acc : head_a;
`else
  assign din = {cmd_op, cmd_a, cmd_b, cmd_tag};
  assign issue_a = head_a;
`endif
  assign head_op = dout[EW-1 -: 4];
  assign head_a = dout[EW-5 -: 8];
  assign head_b = dout[EW-13 -: 8];
  assign head_tag = dout[EW-21 -: TAG_W];
  alu_seq_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(cmd_valid),
    .din(din),
    .pop(pop),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
  assign cmd_ready = !full;
  assign rsp_valid = state == RESP;
  // the ALU result is discarded for divide-by-zero so the response is deterministic
  assign res_next = div_by_zero(alu_sel, alu_b) ? DIV0_RESULT : alu_out;
  always_comb begin
    next_state = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty;
        next_state = empty ? IDLE : EXEC;
      end
      EXEC: next_state = RESP;
      RESP: next_state = rsp_ready ? IDLE : RESP;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= '0;
      tag_q <= '0;
      rsp_result <= '0;
      rsp_carry <= 1'b0;
      rsp_err <= 1'b0;
      rsp_tag <= '0;
`ifdef ALU_SEQ_ACCUM_EN
      acc <= '0;
`endif
    end else begin
      if (pop) begin
        alu_a <= issue_a;
        alu_b <= head_b;
        alu_sel <= head_op;
        tag_q <= head_tag;
      end
      if (state == EXEC) begin
        rsp_result <= res_next;
        rsp_carry <= alu_sel == OP_ADD && alu_carry;
        rsp_err <= div_by_zero(alu_sel, alu_b);
        rsp_tag <= tag_q;
`ifdef ALU_SEQ_ACCUM_EN
        acc <= res_next;
`endif
      end
    end
endmodule
